// File: rtl/cnn_pkg.sv
// Shared CNN helpers: width math, convolution output dimensions and the
// flat (filter, row, column) element index used across the datapath.
package cnn_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_t;

    // Ceiling log2; 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bit width needed to hold 0..v-1, never below one bit.
    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic int conv_out_dim(input int in_dim, input int kernel,
                                        input int pad, input int stride);
        return ((in_dim + 2 * pad - kernel) / stride) + 1;
    endfunction

    function automatic int conv_out_dim_valid(input int in_dim, input int kernel,
                                              input int stride);
        return conv_out_dim(in_dim, kernel, 0, stride);
    endfunction

    function automatic int conv_out_dim_same_pad(input int kernel);
        return (kernel - 1) / 2;
    endfunction

    function automatic int elem_index(input int f, input int h, input int w,
                                      input int height, input int width);
        return (f * height + h) * width + w;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizes one signed accumulator word: arithmetic shift, optional ReLU,
// then saturation into the signed output range.
module requant_sat #(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 8,
    parameter int SHIFT        = 4,
    parameter int RELU_EN      = 1
) (
    input  logic [IN_BITWIDTH-1:0]  x,
    output logic [OUT_BITWIDTH-1:0] y
);

    // One guard bit above the wider operand keeps both bounds representable.
    localparam int W = ((IN_BITWIDTH > OUT_BITWIDTH) ? IN_BITWIDTH : OUT_BITWIDTH) + 1;
    localparam logic signed [W-1:0] SMAX = W'((longint'(1) <<< (OUT_BITWIDTH - 1)) - 1);
    localparam logic signed [W-1:0] SMIN = ~SMAX;

    logic signed [W-1:0] s;

    always_comb begin
        s = W'($signed(x) >>> SHIFT);
        if ((RELU_EN != 0) && (s < 0)) s = '0;
        if (s > SMAX)      y = SMAX[OUT_BITWIDTH-1:0];
        else if (s < SMIN) y = SMIN[OUT_BITWIDTH-1:0];
        else               y = s[OUT_BITWIDTH-1:0];
    end

endmodule

// File: rtl/conv_result_streamer.sv
// Buffers one convolution result frame and streams it out element by element
// (filter-major) as requantized values over a valid/ready interface.
module conv_result_streamer
    import cnn_pkg::*;
#(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 8,
    parameter int FILTERBATCH  = 16,
    parameter int OUT_HEIGHT   = 6,
    parameter int OUT_WIDTH    = 6,
    parameter int SHIFT        = 4,
    parameter int RELU_EN      = 1,
    localparam int FIW = width_of(FILTERBATCH)
) (
    input  logic                                                      clk,
    input  logic                                                      rst_n,
    input  logic [IN_BITWIDTH*FILTERBATCH*OUT_HEIGHT*OUT_WIDTH-1:0]   frame_in,
    input  logic                                                      frame_valid_in,
    output logic [OUT_BITWIDTH-1:0]                                   m_data,
    output logic                                                      m_valid,
    input  logic                                                      m_ready,
    output logic                                                      m_last,
    output logic [FIW-1:0]                                            m_filter_idx,
    output logic                                                      busy,
    output logic                                                      frame_drop
);

    localparam int N   = FILTERBATCH * OUT_HEIGHT * OUT_WIDTH;
    localparam int MAP = OUT_HEIGHT * OUT_WIDTH;
    localparam int IW  = width_of(N);
    localparam int PW  = width_of(MAP);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(MAP - 1);

    stream_state_t state_q, state_d;

    logic [IN_BITWIDTH-1:0] buf_q [N];
    logic [IW-1:0]          idx_q;
    logic [PW-1:0]          pix_q;
    logic [FIW-1:0]         fidx_q;
    logic                   drop_q;

    logic                    capture;
    logic                    advance;
    logic                    cnt_clear;
    logic                    drop_d;
    logic                    at_last;
    logic [OUT_BITWIDTH-1:0] rq;

    assign at_last = (idx_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        advance   = 1'b0;
        cnt_clear = 1'b0;
        drop_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_valid_in) begin
                    capture = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (m_ready) begin
                    if (at_last) begin
                        cnt_clear = 1'b1;
                        if (frame_valid_in) capture = 1'b1;
                        else                state_d = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                // A frame can only be taken on the final handshake; anything else is lost.
                if (frame_valid_in && !(m_ready && at_last)) drop_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else if (capture) begin
            for (int f = 0; f < FILTERBATCH; f++)
                for (int h = 0; h < OUT_HEIGHT; h++)
                    for (int w = 0; w < OUT_WIDTH; w++)
                        buf_q[elem_index(f, h, w, OUT_HEIGHT, OUT_WIDTH)] <=
                            frame_in[elem_index(f, h, w, OUT_HEIGHT, OUT_WIDTH)*IN_BITWIDTH +: IN_BITWIDTH];
        end
    end

    // Feature-map index tracks idx via a per-map pixel counter instead of a divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            pix_q  <= '0;
            fidx_q <= '0;
        end else if (capture || cnt_clear) begin
            idx_q  <= '0;
            pix_q  <= '0;
            fidx_q <= '0;
        end else if (advance) begin
            idx_q <= idx_q + 1'b1;
            if (pix_q == PIX_LAST) begin
                pix_q  <= '0;
                fidx_q <= fidx_q + 1'b1;
            end else begin
                pix_q <= pix_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= 1'b0;
        else        drop_q <= drop_d;
    end

    requant_sat #(
        .IN_BITWIDTH  (IN_BITWIDTH),
        .OUT_BITWIDTH (OUT_BITWIDTH),
        .SHIFT        (SHIFT),
        .RELU_EN      (RELU_EN)
    ) u_requant (
        .x (buf_q[idx_q]),
        .y (rq)
    );

    assign m_valid      = (state_q == ST_STREAM);
    assign busy         = m_valid;
    assign m_last       = m_valid & at_last;
    assign m_data       = m_valid ? rq : '0;
    assign m_filter_idx = fidx_q;
    assign frame_drop   = drop_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Random and directed frames through two streamer instances (ReLU off / on),
// compared beat by beat against a plain-arithmetic requantization model.
module tb_conv_result_streamer;

    localparam int IB = 16;
    localparam int OB = 8;
    localparam int FB = 2;
    localparam int OH = 2;
    localparam int OW = 2;
    localparam int NE = FB * OH * OW;
    localparam int SH = 4;
    localparam int FRW = IB * NE;

    logic           clk;
    logic           rst_n;
    logic [FRW-1:0] frame_in;
    logic           frame_valid_in;
    logic           m_ready;

    logic [OB-1:0] m_data0, m_data1;
    logic          m_valid0, m_valid1, m_last0, m_last1;
    logic          fidx0, fidx1, busy0, busy1, drop0, drop1;

    int total = 0;
    int bad   = 0;

    logic [15:0] cur [NE];
    logic [15:0] nxt [NE];

    conv_result_streamer #(
        .IN_BITWIDTH(IB), .OUT_BITWIDTH(OB), .FILTERBATCH(FB), .OUT_HEIGHT(OH),
        .OUT_WIDTH(OW), .SHIFT(SH), .RELU_EN(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid_in(frame_valid_in),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready), .m_last(m_last0),
        .m_filter_idx(fidx0), .busy(busy0), .frame_drop(drop0)
    );

    conv_result_streamer #(
        .IN_BITWIDTH(IB), .OUT_BITWIDTH(OB), .FILTERBATCH(FB), .OUT_HEIGHT(OH),
        .OUT_WIDTH(OW), .SHIFT(SH), .RELU_EN(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid_in(frame_valid_in),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready), .m_last(m_last1),
        .m_filter_idx(fidx1), .busy(busy1), .frame_drop(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: floor-divide by 2^SH, optional ReLU, clamp to the signed 8-bit range.
    function automatic int requant(input logic [15:0] w, input bit relu);
        int x, s;
        x = (w >= 16'h8000) ? int'(w) - 65536 : int'(w);
        s = x >>> SH;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_frame(input bit use_nxt);
        for (int i = 0; i < NE; i++) frame_in[i*IB +: IB] = use_nxt ? nxt[i] : cur[i];
    endtask

    task automatic randomize_nxt();
        for (int i = 0; i < NE; i++) nxt[i] = 16'($urandom_range(0, 65535));
    endtask

    task automatic send_frame();
        drive_frame(1'b0);
        frame_valid_in = 1'b1;
        @(negedge clk);
        chk("latency_pre_valid", int'(m_valid0), 0);
        @(posedge clk);
        #1;
        frame_valid_in = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
    task automatic run_frame(input int mode, input int drop_beat, input bit b2b);
        int  beat, cyc;
        bit  rdy, dropped, drop_now, drop_prev;
        beat = 0; cyc = 0; dropped = 0; drop_prev = 0;
        while (beat < NE && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            m_ready  = rdy;
            drop_now = 0;
            if (!dropped && beat == drop_beat) begin
                for (int i = 0; i < NE; i++) frame_in[i*IB +: IB] = 16'($urandom_range(0, 65535));
                frame_valid_in = 1'b1;
                dropped  = 1;
                drop_now = 1;
            end
            if (b2b && beat == NE - 1 && rdy) begin
                drive_frame(1'b1);
                frame_valid_in = 1'b1;
            end
            @(negedge clk);
            chk("m_valid", int'(m_valid0), 1);
            chk("busy", int'(busy0), 1);
            chk("m_data_norelu", int'($signed(m_data0)), requant(cur[beat], 1'b0));
            chk("m_data_relu", int'($signed(m_data1)), requant(cur[beat], 1'b1));
            chk("m_last", int'(m_last0), (beat == NE - 1) ? 1 : 0);
            chk("m_last_relu", int'(m_last1), (beat == NE - 1) ? 1 : 0);
            chk("m_filter_idx", int'(fidx0), beat / (OH * OW));
            chk("frame_drop", int'(drop0), int'(drop_prev));
            @(posedge clk);
            #1;
            frame_valid_in = 1'b0;
            drop_prev = drop_now;
            if (rdy) beat++;
            cyc++;
        end
        chk("beats_accepted", beat, NE);
        if (!b2b) begin
            m_ready = 1'b1;
            @(negedge clk);
            chk("idle_m_valid", int'(m_valid0), 0);
            chk("idle_busy", int'(busy0), 0);
            chk("idle_m_last", int'(m_last0), 0);
            chk("idle_m_data", int'(m_data0), 0);
            chk("idle_drop", int'(drop0), int'(drop_prev));
            chk("idle_valid_relu", int'(m_valid1), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        frame_in = '0;
        frame_valid_in = 1'b0;
        m_ready = 1'b0;
        #2;
        chk("rst_m_valid", int'(m_valid0), 0);
        chk("rst_m_last", int'(m_last0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_drop", int'(drop0), 0);
        chk("rst_m_data", int'(m_data0), 0);
        chk("rst_fidx", int'(fidx0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic stream
        for (int i = 0; i < NE; i++) cur[i] = 16'((i + 1) * 16);
        send_frame();
        run_frame(0, -1, 1'b0);

        // Requantization boundaries
        cur = '{16'h7FFF, 16'h8000, 16'hFFF0, 16'h07F0, 16'h0800, 16'hFFFF, 16'hF7F0, 16'hF800};
        send_frame();
        run_frame(0, -1, 1'b0);
        chk("model_sat_hi", requant(16'h0800, 1'b0), 127);
        chk("model_floor_neg", requant(16'hFFFF, 1'b0), -1);

        // Backpressure
        randomize_nxt(); cur = nxt;
        send_frame();
        run_frame(1, -1, 1'b0);

        // Dropped frame mid-stream, with and without stalls
        randomize_nxt(); cur = nxt;
        send_frame();
        run_frame(0, 3, 1'b0);
        randomize_nxt(); cur = nxt;
        send_frame();
        run_frame(1, 3, 1'b0);

        // Back-to-back frames
        randomize_nxt(); cur = nxt;
        send_frame();
        randomize_nxt();
        run_frame(0, -1, 1'b1);
        cur = nxt;
        randomize_nxt();
        run_frame(2, -1, 1'b1);
        cur = nxt;
        run_frame(1, -1, 1'b0);

        // Asynchronous reset mid-stream
        randomize_nxt(); cur = nxt;
        send_frame();
        m_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_data", int'($signed(m_data0)), requant(cur[4], 1'b0));
        chk("pre_rst_fidx", int'(fidx0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", int'(m_valid0), 0);
        chk("async_rst_busy", int'(busy0), 0);
        chk("async_rst_m_last", int'(m_last0), 0);
        chk("async_rst_m_data", int'(m_data0), 0);
        chk("async_rst_fidx", int'(fidx0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b0;
        randomize_nxt(); cur = nxt;
        send_frame();
        run_frame(2, -1, 1'b0);

        // Random soak
        for (int k = 0; k < 6; k++) begin
            randomize_nxt(); cur = nxt;
            send_frame();
            run_frame(k % 3, (k == 4) ? 2 : -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
